// File: rtl/player_motion_ctrl_if.sv
// Button, strobe and sprite-state bundle between the game logic and one
// player_motion_ctrl instance.
interface player_motion_ctrl_if #(
    parameter int FW = 3
);
    // Inputs are level requests, sampled on every clk edge.
    // write_finished is a one-cycle strobe with no ready/backpressure.
    // Outputs are registered and valid on every cycle outside reset.
    logic          move_left;
    logic          move_right;
    logic          jump;
    logic          gaming;
    logic          write_finished;
    logic [11:0]   player_x;
    logic [11:0]   player_y;
    logic [FW-1:0] frame_idx;
    logic          facing;
    logic          airborne;

    modport master (
        output move_left, move_right, jump, gaming, write_finished,
        input  player_x, player_y, frame_idx, facing, airborne
    );

    modport slave (
        input  move_left, move_right, jump, gaming, write_finished,
        output player_x, player_y, frame_idx, facing, airborne
    );
endinterface

// File: rtl/player_motion_ctrl.sv
// Per-player sprite motion: clamped horizontal steps, ballistic jump and a
// walking animation frame counter. Position only moves on frame strobes.
module player_motion_ctrl #(
    parameter int X_INIT      = 50,
    parameter int Y_GROUND    = 380,
    parameter int X_MIN       = 50,
    parameter int X_MAX_SERVE = 200,
    parameter int X_MAX_RALLY = 280,
    parameter int STEP_DIV    = 2,
    parameter int MOVE_STEP   = 4,
    parameter int JUMP_V0     = 8,
    parameter int ANIM_DIV    = 3000000,
    parameter int N_FRAMES    = 5,
    parameter bit FACE_INIT   = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    player_motion_ctrl_if.slave bus
);
    localparam int FW  = $clog2(N_FRAMES);
    localparam int SCW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int ACW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    localparam logic signed [12:0] XMIN_S   = 13'(X_MIN);
    localparam logic signed [12:0] XSERVE_S = 13'(X_MAX_SERVE);
    localparam logic signed [12:0] XRALLY_S = 13'(X_MAX_RALLY);
    localparam logic signed [12:0] STEP_S   = 13'(MOVE_STEP);
    localparam logic signed [12:0] YGND_S   = 13'(Y_GROUND);
    localparam logic signed [7:0]  V0_S     = 8'(JUMP_V0);
    localparam logic [SCW-1:0]     SLAST    = SCW'(STEP_DIV - 1);
    localparam logic [ACW-1:0]     ALAST    = ACW'(ANIM_DIV - 1);
    localparam logic [FW-1:0]      FLAST    = FW'(N_FRAMES - 1);

    typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_t;
    typedef enum logic {ST_GROUND, ST_AIR} vstate_t;

    dir_t                dir;
    vstate_t             state_q, state_d;
    logic [11:0]         x_q, x_d, y_q, y_d;
    logic signed [7:0]   vy_q, vy_d;
    logic [SCW-1:0]      scnt_q, scnt_d;
    logic [ACW-1:0]      acnt_q, acnt_d;
    logic [FW-1:0]       frame_q, frame_d;
    logic                facing_q, facing_d;

    logic signed [12:0]  x_s, y_s, left_x, right_x, bound_s, y_next;

    always_comb begin
        dir = DIR_NONE;
        if (bus.move_left && !bus.move_right)
            dir = DIR_LEFT;
        else if (bus.move_right && !bus.move_left)
            dir = DIR_RIGHT;
    end

    assign x_s     = {1'b0, x_q};
    assign y_s     = {1'b0, y_q};
    assign left_x  = x_s - STEP_S;
    assign right_x = x_s + STEP_S;
    assign bound_s = bus.gaming ? XRALLY_S : XSERVE_S;
    assign y_next  = y_s - {{5{vy_q[7]}}, vy_q};

    // Horizontal stepping; a right step never pulls x back inside a
    // bound that shrank under it (gaming dropped mid-rally).
    always_comb begin
        x_d    = x_q;
        scnt_d = scnt_q;
        if (bus.write_finished) begin
            if (dir == DIR_NONE) begin
                scnt_d = '0;
            end else if (scnt_q == SLAST) begin
                scnt_d = '0;
                if (dir == DIR_LEFT)
                    x_d = (left_x < XMIN_S) ? XMIN_S[11:0] : left_x[11:0];
                else if (x_s <= bound_s)
                    x_d = (right_x > bound_s) ? bound_s[11:0] : right_x[11:0];
            end else begin
                scnt_d = scnt_q + 1'b1;
            end
        end
    end

    // Vertical FSM: launch leaves y alone, later strobes integrate vy.
    always_comb begin
        state_d = state_q;
        vy_d    = vy_q;
        y_d     = y_q;
        if (bus.write_finished) begin
            case (state_q)
                ST_GROUND: begin
                    if (bus.jump) begin
                        state_d = ST_AIR;
                        vy_d    = V0_S;
                    end
                end
                ST_AIR: begin
                    if (y_next >= YGND_S) begin
                        state_d = ST_GROUND;
                        vy_d    = '0;
                        y_d     = YGND_S[11:0];
                    end else begin
                        y_d  = y_next[11:0];
                        vy_d = vy_q - 8'sd1;
                    end
                end
                default: state_d = ST_GROUND;
            endcase
        end
    end

    // Walk animation runs on clk, only while walking on the ground.
    always_comb begin
        acnt_d   = '0;
        frame_d  = '0;
        facing_d = facing_q;
        if (dir != DIR_NONE)
            facing_d = (dir == DIR_RIGHT);
        if (dir != DIR_NONE && state_q == ST_GROUND) begin
            frame_d = frame_q;
            if (acnt_q == ALAST) begin
                if (dir == DIR_RIGHT)
                    frame_d = (frame_q == FLAST) ? '0 : frame_q + 1'b1;
                else
                    frame_d = (frame_q == '0) ? FLAST : frame_q - 1'b1;
            end else begin
                acnt_d = acnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_GROUND;
            x_q      <= 12'(X_INIT);
            y_q      <= 12'(Y_GROUND);
            vy_q     <= '0;
            scnt_q   <= '0;
            acnt_q   <= '0;
            frame_q  <= '0;
            facing_q <= FACE_INIT;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            vy_q     <= vy_d;
            scnt_q   <= scnt_d;
            acnt_q   <= acnt_d;
            frame_q  <= frame_d;
            facing_q <= facing_d;
        end
    end

    assign bus.player_x  = x_q;
    assign bus.player_y  = y_q;
    assign bus.frame_idx = frame_q;
    assign bus.facing    = facing_q;
    assign bus.airborne  = (state_q == ST_AIR);
endmodule

// File: tb/tb_player_motion_ctrl.sv
// Scoreboard bench for player_motion_ctrl: a behavioural model pushes the
// expected registered outputs each cycle, popped after the clock edge.
module tb_player_motion_ctrl;
    localparam int N_FRAMES = 5;
    localparam int ANIM_DIV = 3;
    localparam int STEP_DIV = 2;
    localparam int FW       = 3;
    localparam int W        = 12 + 12 + 1 + FW + 1;

    logic clk;
    logic rst_n;
    player_motion_ctrl_if #(.FW(FW)) bus ();

    player_motion_ctrl #(
        .X_INIT(50), .Y_GROUND(380), .X_MIN(50), .X_MAX_SERVE(200),
        .X_MAX_RALLY(280), .STEP_DIV(STEP_DIV), .MOVE_STEP(4), .JUMP_V0(8),
        .ANIM_DIV(ANIM_DIV), .N_FRAMES(N_FRAMES), .FACE_INIT(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    bit in_l, in_r, in_j, in_g;
    int m_x, m_y, m_vy, m_scnt, m_acnt, m_frame;
    bit m_air, m_face;

    int y_tab[17] = '{372, 365, 359, 354, 350, 347, 345, 344, 344,
                      345, 347, 350, 354, 359, 365, 372, 380};

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 50; m_y = 380; m_vy = 0; m_scnt = 0; m_acnt = 0;
        m_frame = 0; m_air = 1'b0; m_face = 1'b1;
    endtask

    task automatic set_in(input bit l, input bit r, input bit j, input bit g);
        in_l = l; in_r = r; in_j = j; in_g = g;
        bus.move_left = l; bus.move_right = r; bus.jump = j; bus.gaming = g;
    endtask

    task automatic model_step(input bit wf);
        int d, bound, yn;
        d = (in_l && !in_r) ? 1 : ((in_r && !in_l) ? 2 : 0);
        if (d != 0 && !m_air) begin
            if (m_acnt == ANIM_DIV - 1) begin
                m_acnt = 0;
                m_frame = (d == 2) ? (m_frame + 1) % N_FRAMES
                                   : (m_frame + N_FRAMES - 1) % N_FRAMES;
            end else begin
                m_acnt++;
            end
        end else begin
            m_acnt = 0;
            m_frame = 0;
        end
        if (d != 0) m_face = (d == 2);
        if (wf) begin
            bound = in_g ? 280 : 200;
            if (d == 0) m_scnt = 0;
            else if (m_scnt == STEP_DIV - 1) begin
                m_scnt = 0;
                if (d == 1) m_x = (m_x - 4 < 50) ? 50 : m_x - 4;
                else if (m_x <= bound) m_x = (m_x + 4 > bound) ? bound : m_x + 4;
            end else m_scnt++;
            if (!m_air) begin
                if (in_j) begin m_air = 1'b1; m_vy = 8; end
            end else begin
                yn = m_y - m_vy;
                if (yn >= 380) begin m_y = 380; m_vy = 0; m_air = 1'b0; end
                else begin m_y = yn; m_vy = m_vy - 1; end
            end
        end
    endtask

    // driver: called at a negedge with inputs already set
    task automatic tick(input bit wf);
        logic [W-1:0] e;
        bus.write_finished = wf;
        model_step(wf);
        exp_q.push_back({m_x[11:0], m_y[11:0], m_air, m_frame[FW-1:0], m_face});
        @(negedge clk);
        bus.write_finished = 1'b0;
        if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL sb_empty: got 0 entries expected 1");
        end else begin
            e = exp_q.pop_front();
            check_eq("x", 32'(bus.player_x), 32'(e[W-1 -: 12]));
            check_eq("y", 32'(bus.player_y), 32'(e[W-13 -: 12]));
            check_eq("air", 32'(bus.airborne), 32'(e[FW+1]));
            check_eq("frame", 32'(bus.frame_idx), 32'(e[FW:1]));
            check_eq("facing", 32'(bus.facing), 32'(e[0]));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.write_finished = 1'b0;
        set_in(0, 0, 0, 0);
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_x", 32'(bus.player_x), 50);
        check_eq("rst_y", 32'(bus.player_y), 380);
        check_eq("rst_frame", 32'(bus.frame_idx), 0);
        check_eq("rst_facing", 32'(bus.facing), 1);
        check_eq("rst_air", 32'(bus.airborne), 0);
        rst_n = 1'b1;

        // right steps and serve-side saturation
        set_in(0, 1, 0, 0);
        tick(1); check_eq("step1_x", 32'(bus.player_x), 50);
        tick(1); check_eq("step2_x", 32'(bus.player_x), 54);
        repeat (80) begin tick(1); tick(0); end
        check_eq("serve_sat", 32'(bus.player_x), 200);

        // rally clamp, then gaming drops with x beyond the serve bound
        set_in(0, 1, 0, 1);
        repeat (50) tick(1);
        check_eq("rally_sat", 32'(bus.player_x), 280);
        set_in(0, 1, 0, 0);
        repeat (4) tick(1);
        check_eq("no_pull_back", 32'(bus.player_x), 280);
        set_in(0, 0, 0, 0); tick(1);
        set_in(1, 0, 0, 0); repeat (2) tick(1);
        check_eq("left_after_drop", 32'(bus.player_x), 276);

        // single jump arc
        set_in(0, 0, 1, 0); tick(1);
        check_eq("launch_y", 32'(bus.player_y), 380);
        check_eq("launch_air", 32'(bus.airborne), 1);
        set_in(0, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            tick(1); tick(0);
            check_eq("arc_y", 32'(bus.player_y), 32'(y_tab[i]));
            check_eq("arc_air", 32'(bus.airborne), (i == 16) ? 0 : 1);
        end

        // held jump relaunches one strobe after landing
        set_in(0, 0, 1, 0); tick(1);
        repeat (17) tick(1);
        check_eq("held_land_air", 32'(bus.airborne), 0);
        tick(1);
        check_eq("held_relaunch_air", 32'(bus.airborne), 1);
        set_in(0, 0, 0, 0);
        repeat (17) tick(1);

        // animation, reversal and release
        tick(0);
        set_in(0, 1, 0, 0); repeat (6) tick(0);
        check_eq("anim_r2", 32'(bus.frame_idx), 2);
        set_in(1, 0, 0, 0); repeat (9) tick(0);
        check_eq("anim_l4", 32'(bus.frame_idx), 4);
        check_eq("face_left", 32'(bus.facing), 0);
        set_in(0, 0, 0, 0); tick(0);
        check_eq("anim_release", 32'(bus.frame_idx), 0);
        set_in(0, 1, 0, 0); repeat (16) tick(0);

        // both buttons: no move, idle frame, facing held
        set_in(1, 1, 0, 0); repeat (4) tick(1);
        check_eq("both_frame", 32'(bus.frame_idx), 0);
        check_eq("both_facing", 32'(bus.facing), 1);

        // asynchronous reset mid-flight
        set_in(0, 0, 1, 0); tick(1);
        set_in(0, 0, 0, 0); repeat (4) tick(1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("amid_y", 32'(bus.player_y), 380);
        check_eq("amid_air", 32'(bus.airborne), 0);
        check_eq("amid_x", 32'(bus.player_x), 50);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // random mix
        for (int i = 0; i < 800; i++) begin
            set_in($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 5) == 0,
                   (i % 200) < 120 ? 1'b1 : 1'b0);
            tick($urandom_range(0, 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
